// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot strobe word, with sticky illegal-strobe tracking.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_onehot_wr #(
  parameter int DATA_W    = 32,
  parameter int ZERO_REG  = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wr_sel,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [4:0]           rd_addr_a,
  input  logic [4:0]           rd_addr_b,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 onehot_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [32];
  logic              sel_zero;
  logic              multi_hot;
  logic              one_hot;

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  always_comb begin
    sel_zero  = (wr_sel == 32'd0);
    multi_hot = |(wr_sel & (wr_sel - 32'd1));
    one_hot   = !sel_zero && !multi_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (one_hot) begin
      for (int i = 0; i < 32; i++) begin
        if (wr_sel[i] && !(ZERO_REG != 0 && i == 0)) regs[i] <= wr_data;
      end
    end
  end

  // A fresh illegal strobe wins over a simultaneous clear, restarting the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_err <= 1'b0;
      err_count  <= '0;
    end else if (multi_hot) begin
      onehot_err <= 1'b1;
      if (err_clr) err_count <= CNT_ONE;
      else if (!(&err_count)) err_count <= err_count + CNT_ONE;
    end else if (err_clr) begin
      onehot_err <= 1'b0;
      err_count  <= '0;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && one_hot && wr_sel[rd_addr_a]) rd_data_a = wr_data;
`endif
    if (ZERO_REG != 0 && rd_addr_a == 5'd0) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (!rst && one_hot && wr_sel[rd_addr_b]) rd_data_b = wr_data;
`endif
    if (ZERO_REG != 0 && rd_addr_b == 5'd0) rd_data_b = '0;
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr: one DUT with a hardwired r0, one with an ordinary r0,
// both checked each cycle against an array-based model plus hand-computed literal checks.
module tb_regfile_onehot_wr;

  logic        clk;
  logic        rst;
  logic [31:0] wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        err_clr;

  logic [31:0] rd_data_a,  rd_data_b;
  logic        onehot_err;
  logic [7:0]  err_count;
  logic [31:0] rd_data_a0, rd_data_b0;
  logic        onehot_err0;
  logic [7:0]  err_count0;

  int cmp_count  = 0;
  int fail_count = 0;
  bit chk_en     = 0;

  logic [31:0] mregs [2][32];
  int          merr;
  int          mcnt;

  regfile_onehot_wr #(.DATA_W(32), .ZERO_REG(1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .err_clr(err_clr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .onehot_err(onehot_err), .err_count(err_count)
  );

  regfile_onehot_wr #(.DATA_W(32), .ZERO_REG(0), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .err_clr(err_clr),
    .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
    .onehot_err(onehot_err0), .err_count(err_count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] sel, input logic [31:0] data,
                               input logic [4:0] a, input logic [4:0] b,
                               input logic clr, input logic r);
    @(posedge clk);
    #1;
    wr_sel    = sel;
    wr_data   = data;
    rd_addr_a = a;
    rd_addr_b = b;
    err_clr   = clr;
    rst       = r;
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b);
    applyStimulus(32'd0, 32'd0, a, b, 1'b0, 1'b0);
  endtask

  // Model: index 0 mirrors the hardwired-r0 instance, index 1 the ordinary-r0 instance.
  always @(posedge clk) begin
    int n;
    n = $countones(wr_sel);
    if (rst) begin
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < 32; i++) mregs[z][i] = 32'd0;
      merr = 0;
      mcnt = 0;
    end else begin
      if (n == 1) begin
        for (int i = 0; i < 32; i++) begin
          if (wr_sel[i]) begin
            if (i != 0) mregs[0][i] = wr_data;
            mregs[1][i] = wr_data;
          end
        end
      end
      if (n > 1) begin
        merr = 1;
        mcnt = err_clr ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
      end else if (err_clr) begin
        merr = 0;
        mcnt = 0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int z, input logic [4:0] addr);
    if (z == 0 && addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && $countones(wr_sel) == 1 && wr_sel[addr]) return wr_data;
`endif
    return mregs[z][addr];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_rd_a_zr1", rd_data_a,  exp_rd(0, rd_addr_a));
      checkOutput("model_rd_b_zr1", rd_data_b,  exp_rd(0, rd_addr_b));
      checkOutput("model_rd_a_zr0", rd_data_a0, exp_rd(1, rd_addr_a));
      checkOutput("model_rd_b_zr0", rd_data_b0, exp_rd(1, rd_addr_b));
      checkOutput("model_err_zr1",  onehot_err,  merr);
      checkOutput("model_cnt_zr1",  err_count,   mcnt);
      checkOutput("model_err_zr0",  onehot_err0, merr);
      checkOutput("model_cnt_zr0",  err_count0,  mcnt);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst = 1'b1; wr_sel = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; err_clr = 1'b0;
    applyStimulus(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(5'd0, 5'd0);
    @(negedge clk);
    chk_en = 1;
    checkOutput("reset_err", onehot_err, 1'b0);
    checkOutput("reset_cnt", err_count, 8'd0);

    // Reset flush of a written register
    applyStimulus(32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 1'b0);
    idle(5'd5, 5'd5);
    @(negedge clk);
    checkOutput("r5_written", rd_data_a, 32'hDEAD_BEEF);
    applyStimulus(32'd0, 32'd0, 5'd5, 5'd5, 1'b0, 1'b1);
    idle(5'd5, 5'd5);
    @(negedge clk);
    checkOutput("r5_flushed", rd_data_a, 32'd0);
    checkOutput("flush_err", onehot_err, 1'b0);
    checkOutput("flush_cnt", err_count, 8'd0);

    // Basic write/read on both ports
    applyStimulus(32'h0000_0400, 32'h1234_5678, 5'd10, 5'd10, 1'b0, 1'b0);
    idle(5'd10, 5'd10);
    @(negedge clk);
    checkOutput("r10_port_a", rd_data_a, 32'h1234_5678);
    checkOutput("r10_port_b", rd_data_b, 32'h1234_5678);
    idle(5'd9, 5'd11);
    @(negedge clk);
    checkOutput("r9_untouched",  rd_data_a, 32'd0);
    checkOutput("r11_untouched", rd_data_b, 32'd0);

    // Register 0 behaviour for both parameterisations
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(5'd0, 5'd0);
    @(negedge clk);
    checkOutput("r0_hardwired", rd_data_a, 32'd0);
    checkOutput("r0_ordinary",  rd_data_a0, 32'hFFFF_FFFF);
    checkOutput("r0_no_err",    onehot_err, 1'b0);

    // Illegal strobe leaves registers intact and counts
    applyStimulus(32'h0000_0008, 32'hAAAA_AAAA, 5'd3, 5'd4, 1'b0, 1'b0);
    applyStimulus(32'h0000_0010, 32'h5555_5555, 5'd3, 5'd4, 1'b0, 1'b0);
    applyStimulus(32'h0000_0018, 32'h0000_0000, 5'd3, 5'd4, 1'b0, 1'b0);
    idle(5'd3, 5'd4);
    @(negedge clk);
    checkOutput("r3_kept",      rd_data_a, 32'hAAAA_AAAA);
    checkOutput("r4_kept",      rd_data_b, 32'h5555_5555);
    checkOutput("illegal_err",  onehot_err, 1'b1);
    checkOutput("illegal_cnt",  err_count, 8'd1);
    for (int k = 0; k < 300; k++)
      applyStimulus(32'h0000_0018, 32'h0000_0000, 5'd3, 5'd4, 1'b0, 1'b0);
    idle(5'd3, 5'd4);
    @(negedge clk);
    checkOutput("cnt_saturated", err_count, 8'd255);
    checkOutput("cnt_sat_zr0",   err_count0, 8'd255);
    checkOutput("r3_after_burst", rd_data_a, 32'hAAAA_AAAA);

    // Clear versus error collision
    applyStimulus(32'd0, 32'd0, 5'd3, 5'd4, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++)
      applyStimulus(32'h0000_0300, 32'h0000_0000, 5'd3, 5'd4, 1'b0, 1'b0);
    idle(5'd3, 5'd4);
    @(negedge clk);
    checkOutput("cnt_seven", err_count, 8'd7);
    applyStimulus(32'h8000_0001, 32'h0000_0000, 5'd3, 5'd4, 1'b1, 1'b0);
    idle(5'd3, 5'd4);
    @(negedge clk);
    checkOutput("collide_err", onehot_err, 1'b1);
    checkOutput("collide_cnt", err_count, 8'd1);
    applyStimulus(32'd0, 32'd0, 5'd3, 5'd4, 1'b1, 1'b0);
    idle(5'd3, 5'd4);
    @(negedge clk);
    checkOutput("cleared_err", onehot_err, 1'b0);
    checkOutput("cleared_cnt", err_count, 8'd0);

    // Same-cycle visibility of a write
    applyStimulus(32'h0000_0080, 32'h1111_1111, 5'd7, 5'd7, 1'b0, 1'b0);
    applyStimulus(32'h0000_0080, 32'hCAFE_F00D, 5'd7, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_before_edge", rd_data_a, 32'hCAFE_F00D);
`else
    checkOutput("bypass_before_edge", rd_data_a, 32'h1111_1111);
`endif
    checkOutput("other_port_plain", rd_data_b, 32'hAAAA_AAAA);
    idle(5'd7, 5'd7);
    @(negedge clk);
    checkOutput("after_edge", rd_data_a, 32'hCAFE_F00D);
    applyStimulus(32'h0000_0180, 32'h0000_0000, 5'd7, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("illegal_no_fwd", rd_data_a, 32'hCAFE_F00D);
    applyStimulus(32'h0000_0001, 32'h0BAD_0BAD, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("r0_no_fwd_zr1", rd_data_a, 32'd0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("r0_fwd_zr0", rd_data_a0, 32'h0BAD_0BAD);
`else
    checkOutput("r0_fwd_zr0", rd_data_a0, 32'hFFFF_FFFF);
`endif
    applyStimulus(32'h0000_0080, 32'h0000_0099, 5'd7, 5'd7, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_no_fwd", rd_data_a, 32'hCAFE_F00D);
    idle(5'd7, 5'd0);
    @(negedge clk);
    checkOutput("rst_wins_write", rd_data_a, 32'd0);
    checkOutput("rst_clears_r0_zr0", rd_data_b0, 32'd0);

    idle(5'd0, 5'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
